// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: shares the CAN controller TX FIFO write port between
// N_REQ requesters (round-robin) and a periodic heartbeat word that has
// priority over all requesters. One output register holds each word until
// the controller takes it; accepted words are counted in word_cnt.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1.
// Requester side: req_ready is combinational and only ever asserted in IDLE,
// one-hot, to the port being loaded that cycle. Controller side: tx_valid
// comes straight from the FSM state register and never depends on tx_ready;
// once raised, tx_data/tx_src stay stable until tx_ready is seen.
module can_tx_scheduler #(
  parameter int          N_REQ     = 4,
  parameter logic [31:0] HB_PERIOD = 32'd50_000_000,
  parameter logic [15:0] HB_TAG    = 16'hA55A
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic                 hb_enable,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [31:0]          tx_data,
  output logic [3:0]           tx_src,
  output logic                 hb_missed,
  output logic [15:0]          word_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_e;

  state_e      state_q;
  logic [2:0]  rr_ptr_q;
  logic [31:0] tx_data_q;
  logic [3:0]  tx_src_q;
  logic [15:0] word_cnt_q;
  logic [15:0] hb_seq_q;
  logic [31:0] hb_cnt_q, hb_cnt_d;
  logic        hb_pending_q, hb_pending_d;
  logic        hb_missed_q;

  logic        found;
  logic [2:0]  sel;
  logic [31:0] sel_data;
  logic        hb_load;
  logic        req_load;
  logic        hb_active;
  logic        hb_tc;

  // Heartbeat wins an IDLE cycle; otherwise the round-robin winner is loaded.
  // Gated by rstn so req_ready reads 0 while reset is held.
  assign hb_load   = rstn && (state_q == S_IDLE) && hb_pending_q && hb_enable;
  assign req_load  = rstn && (state_q == S_IDLE) && !hb_load && found;
  assign hb_active = hb_enable && (HB_PERIOD != 32'd0);
  assign hb_tc     = hb_active && (hb_cnt_q == HB_PERIOD - 32'd1);

  // Round-robin search: ports above rr_ptr first, then wrap to 0..rr_ptr.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (3'(i) > rr_ptr_q)) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (3'(i) <= rr_ptr_q)) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
  end

  // One-hot accept and data mux for the selected requester.
  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = req_load && (sel == 3'(i));
      if (sel == 3'(i)) sel_data = req_data[32*i +: 32];
    end
  end

  // Heartbeat timer next state; a terminal count beats a same-cycle load.
  always_comb begin
    hb_cnt_d     = hb_cnt_q + 32'd1;
    hb_pending_d = hb_pending_q;
    if (!hb_active || hb_tc) hb_cnt_d = 32'd0;
    if (!hb_enable)          hb_pending_d = 1'b0;
    else if (hb_tc)          hb_pending_d = 1'b1;
    else if (hb_load)        hb_pending_d = 1'b0;
  end

  // Heartbeat timer, pending flag and overrun pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hb_cnt_q     <= 32'd0;
      hb_pending_q <= 1'b0;
      hb_missed_q  <= 1'b0;
    end else begin
      hb_cnt_q     <= hb_cnt_d;
      hb_pending_q <= hb_pending_d;
      hb_missed_q  <= hb_tc && hb_pending_q && !hb_load;
    end
  end

  // Output FSM: IDLE loads the output register, HOLD waits for tx_ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 3'(N_REQ - 1);
      tx_data_q  <= 32'd0;
      tx_src_q   <= 4'd0;
      word_cnt_q <= 16'd0;
      hb_seq_q   <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hb_load) begin
            tx_data_q <= {HB_TAG, hb_seq_q};
            tx_src_q  <= 4'hF;
            state_q   <= S_HOLD;
          end else if (req_load) begin
            tx_data_q <= sel_data;
            tx_src_q  <= {1'b0, sel};
            rr_ptr_q  <= sel;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (tx_ready) begin
            word_cnt_q <= word_cnt_q + 16'd1;
            if (tx_src_q == 4'hF) hb_seq_q <= hb_seq_q + 16'd1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_valid  = (state_q == S_HOLD);
  assign tx_data   = tx_data_q;
  assign tx_src    = tx_src_q;
  assign hb_missed = hb_missed_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_can_tx_scheduler;

  localparam int          N    = 4;
  localparam logic [31:0] HBP  = 32'd40;
  localparam logic [15:0] TAG  = 16'hA55A;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [32*N-1:0]  req_data;
  logic             hb_enable;
  logic             tx_valid;
  logic             tx_ready;
  logic [31:0]      tx_data;
  logic [3:0]       tx_src;
  logic             hb_missed;
  logic [15:0]      word_cnt;

  always #5 clk = ~clk;

  can_tx_scheduler #(.N_REQ(N), .HB_PERIOD(HBP), .HB_TAG(TAG)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .hb_enable(hb_enable),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_src(tx_src), .hb_missed(hb_missed), .word_cnt(word_cnt)
  );

  // ---------------- stimulus state ----------------
  bit          rv[N];
  logic [31:0] rd[N];
  bit          hb_en;
  bit          rdy;
  int          mode;        // 0: drop valid after grant, 1: refill, 2: random

  // ---------------- reference model ----------------
  bit          m_hold;
  logic [31:0] m_word;
  logic [3:0]  m_src;
  logic [15:0] m_cnt;
  int          m_last;
  bit          m_pend;
  logic [15:0] m_seq;
  int          m_timer;
  bit          m_missed;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [35:0] acc_log[$];
  int          acc_cyc[$];
  int          grant_log[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          missed_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_word = '0; m_src = '0; m_cnt = '0; m_last = N - 1;
    m_pend = 0; m_seq = '0; m_timer = 0; m_missed = 0;
    exp_q.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rv[i];
      req_data[32*i +: 32] = rd[i];
    end
    hb_enable = hb_en;
    tx_ready  = rdy;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_valid"},  tx_valid,  0);
    chk({tag, "_tx_data"},   tx_data,   0);
    chk({tag, "_tx_src"},    tx_src,    0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_hb_missed"}, hb_missed, 0);
    chk({tag, "_word_cnt"},  word_cnt,  0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < N; i++) rv[i] = 1;
    drive();
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < N; i++) rv[i] = 0;
    model_reset();
  endtask

  task automatic refill(input int p);
    if (mode == 1) rd[p] = $urandom;
    else rv[p] = 0;
  endtask

  // One clock cycle: drive at negedge, compare, advance the model, wait.
  task automatic step();
    int win;
    int j;
    bit hbl;
    bit tc;
    bit newmiss;
    logic [N-1:0] exp_rdy;
    drive();
    #2;
    win = -1;
    hbl = 0;
    if (!m_hold) begin
      if (m_pend && hb_en) hbl = 1;
      else begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (win < 0 && rv[j]) win = j;
        end
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("tx_valid",  tx_valid,  m_hold);
    chk("tx_data",   tx_data,   m_word);
    chk("tx_src",    tx_src,    m_src);
    chk("word_cnt",  word_cnt,  m_cnt);
    chk("hb_missed", hb_missed, m_missed);
    if (hb_missed === 1'b1) missed_seen++;
    if (m_hold && rdy) begin
      if (exp_q.size() != 0) chk("sb_word", tx_data, exp_q.pop_front());
      acc_log.push_back({tx_src, tx_data});
      acc_cyc.push_back(cyc);
      m_cnt = m_cnt + 16'd1;
      if (m_src == 4'hF) m_seq = m_seq + 16'd1;
      m_hold = 0;
    end
    if (hbl) begin
      m_word = {TAG, m_seq}; m_src = 4'hF; m_hold = 1;
      exp_q.push_back(m_word);
    end else if (win >= 0) begin
      m_word = rd[win]; m_src = 4'(win); m_hold = 1; m_last = win;
      exp_q.push_back(m_word);
      grant_log.push_back(win);
      refill(win);
    end
    tc = 0;
    if (hb_en && HBP != 0) begin
      if (m_timer == int'(HBP) - 1) begin tc = 1; m_timer = 0; end
      else m_timer++;
    end else m_timer = 0;
    newmiss = 0;
    if (!hb_en) m_pend = 0;
    else if (tc) begin newmiss = m_pend && !hbl; m_pend = 1; end
    else if (hbl) m_pend = 0;
    m_missed = newmiss;
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int cnt[N];
    logic [15:0] snap;
    int hbs;
    for (int i = 0; i < N; i++) begin rv[i] = 0; rd[i] = '0; end
    hb_en = 0; rdy = 0; mode = 0;
    rstn = 1'b0;
    drive();
    @(negedge clk);
    do_reset();

    // single requester on port 2
    rdy = 1; mode = 0;
    rv[2] = 1; rd[2] = 32'h11223344;
    acc_log.delete(); acc_cyc.delete();
    for (int i = 0; i < 4; i++) step();
    chk("single_word", acc_log[0], {4'h2, 32'h11223344});
    chk("single_cnt", word_cnt, 16'd1);

    // round-robin from reset, all ports valid
    @(negedge clk);
    do_reset();
    mode = 1; rdy = 1;
    for (int i = 0; i < N; i++) begin rv[i] = 1; rd[i] = $urandom; end
    grant_log.delete();
    for (int i = 0; i < 16; i++) step();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", grant_log[i], i % N);
      if (grant_log[i] >= 0 && grant_log[i] < N) cnt[grant_log[i]]++;
    end
    for (int i = 0; i < N; i++) chk("rr_share", cnt[i], 2);

    // backpressure while holding
    rdy = 0;
    step();
    snap = word_cnt;
    for (int i = 0; i < 10; i++) step();
    chk("bp_cnt_hold", word_cnt, snap);
    rdy = 1;
    step();
    rdy = 0;
    for (int i = 0; i < 3; i++) step();
    chk("bp_one_word", word_cnt, snap + 16'd1);

    // asynchronous reset while a word is held
    chk("pre_reset_valid", tx_valid, 1);
    #3;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    mode = 1; rdy = 1;
    for (int i = 0; i < N; i++) rv[i] = 1;
    grant_log.delete();
    step();
    chk("post_reset_first", grant_log[0], 0);
    step(); step();

    // heartbeat only, ports idle
    do_reset();
    mode = 0; rdy = 1; hb_en = 1;
    acc_log.delete(); acc_cyc.delete();
    for (int i = 0; i < 100; i++) step();
    chk("hb_word0", acc_log[0], {4'hF, 32'hA55A0000});
    chk("hb_word1", acc_log[1], {4'hF, 32'hA55A0001});
    chk("hb_spacing", acc_cyc[1] - acc_cyc[0], int'(HBP));

    // heartbeat priority and overrun under backpressure
    hb_en = 0;
    do_reset();
    mode = 1; rdy = 0; hb_en = 1;
    rv[0] = 1; rd[0] = $urandom;
    missed_seen = 0;
    for (int i = 0; i < 100; i++) step();
    chk("hb_missed_seen", missed_seen > 0, 1);
    acc_log.delete();
    rdy = 1;
    for (int i = 0; i < 12; i++) step();
    chk("ovr_src0", acc_log[0][35:32], 4'h0);
    chk("ovr_src1", acc_log[1][35:32], 4'hF);
    chk("ovr_src2", acc_log[2][35:32], 4'h0);
    hbs = 0;
    for (int i = 0; i < 5; i++) if (acc_log[i][35:32] == 4'hF) hbs++;
    chk("ovr_single_hb", hbs, 1);

    // random traffic against the model
    hb_en = 0;
    do_reset();
    mode = 2; hb_en = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 3) == 0) begin rv[i] = 1; rd[i] = $urandom; end
        else if (rv[i] && $urandom_range(0, 15) == 0) rv[i] = 0;
      end
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 63) == 0) hb_en = !hb_en;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
# can_tx_scheduler

Sequencer and arbiter in front of the CAN controller's 32-bit TX FIFO write port (`tx_valid`/`tx_ready`/`tx_data`). It shares that single port between `N_REQ` independent requesters using round-robin arbitration. It also injects a periodic heartbeat word that has priority over all requesters. Each forwarded word is held in one output register until the controller accepts it, and every accepted word is counted.

## Interface
- `N_REQ`, default 4, number of requester ports, legal range 2..8.
- `HB_PERIOD`, default 32'd50_000_000, heartbeat period in clk cycles (1 s at 50 MHz). A value of 0 disables heartbeat generation permanently.
- `HB_TAG`, default 16'hA55A, upper half of the heartbeat word.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous active-low reset; the block operates while it is 1.
- `req_valid`  in  N_REQ  per-requester word available.
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero, combinational.
- `req_data`  in  32*N_REQ  requester i occupies bits [32*i+31:32*i].
- `hb_enable`  in  1  heartbeat generation enable.
- `tx_valid`  out  1  word available to the CAN controller FIFO.
- `tx_ready`  in  1  CAN controller FIFO not full.
- `tx_data`  out  32  word pushed to the FIFO.
- `tx_src`  out  4  source of the current `tx_data`: 0..N_REQ-1 for a requester, 4'hF for the heartbeat.
- `hb_missed`  out  1  one-cycle pulse when a heartbeat period expires while the previous heartbeat is still pending.
- `word_cnt`  out  16  number of words accepted by the controller, wraps modulo 2^16.

## Operation
- FSM has two states: IDLE (output register empty) and HOLD (output register full, `tx_valid`=1).
- IDLE, heartbeat branch: if `hb_pending` & `hb_enable` are both 1, load `tx_data`={HB_TAG, hb_seq}, set `tx_src`=4'hF, clear `hb_pending`, go to HOLD. All `req_ready` bits are 0 in that cycle.
- IDLE, requester branch: otherwise, `sel` is the first index with `req_valid` set, searching from (`rr_ptr`+1) mod N_REQ upward with wrap.
  - `req_ready[sel]`=1 combinationally.
  - The handshake completes in the same cycle.
  - Load `tx_data`=req_data[sel], `tx_src`=sel, `rr_ptr`<=sel, go to HOLD.
- IDLE with no request and no eligible heartbeat: remain in IDLE.
- HOLD: all `req_ready` bits are 0. `tx_data` and `tx_src` are stable. On `tx_valid`&`tx_ready`: `word_cnt`++; if the word was a heartbeat, `hb_seq`++ (16-bit wrap); go to IDLE.
- Heartbeat timer, 32-bit `hb_cnt`, active when `hb_enable`=1 and HB_PERIOD≠0:
  - `hb_cnt` counts 0..HB_PERIOD-1 and wraps.
  - At terminal count, `hb_pending`<=1.
  - If `hb_pending` is already 1 at terminal count, it stays 1 (no queuing) and `hb_missed` pulses.
- `hb_enable`=0: `hb_cnt` is held at 0 and `hb_pending` is cleared. A heartbeat already loaded into HOLD still completes.
- Requesters must hold `req_data` stable while `req_valid`=1. A requester may deassert `req_valid` at any time before its handshake.
- Reset values: `tx_valid`=0, `tx_data`=0, `tx_src`=0, `req_ready`=0, `hb_missed`=0, `word_cnt`=0, `rr_ptr`=N_REQ-1 (port 0 wins first), `hb_cnt`=0, `hb_pending`=0, `hb_seq`=0, state IDLE.
- Reset mid-operation: any word in HOLD is dropped, no `word_cnt` increment.

## Timing
- Requester handshake in cycle T → `tx_valid`=1 from T+1.
- Controller accepts in cycle H → `tx_valid`=0 at H+1 and the FSM is in IDLE at H+1.
- The next requester handshake is possible at H+1, with `tx_valid` again at H+2.
- Sustained throughput: one word per 2 cycles when `tx_ready` is held at 1.
- `tx_ready` is ignored in IDLE; no combinational path from `tx_ready` to `tx_valid`.
- Terminal count of `hb_cnt` in cycle C → `hb_pending`=1 at C+1. The heartbeat is loaded in the first IDLE cycle ≥ C+1 and overrides any simultaneous requests in that cycle.
- Terminal count in the same cycle as the heartbeat load: `hb_pending` ends at 1 (set wins over clear), no `hb_missed`.
- `word_cnt` 16'hFFFF + 1 → 16'h0000.

## Test plan
- Single requester: N_REQ=4, port 2 offers 32'h11223344, `tx_ready`=1.
  → `req_ready`=4'b0100 for 1 cycle, then `tx_valid`=1 for 1 cycle with `tx_data`=32'h11223344, `tx_src`=2, `word_cnt`=1.
- Round-robin: all four ports valid continuously after reset.
  → grant order 0,1,2,3,0,1,…; each port receives exactly 2 grants in 8 words.
- Backpressure: `tx_ready`=0 for 10 cycles while in HOLD.
  → `tx_data` and `tx_src` are stable, `req_ready`=0, `word_cnt` is unchanged.
  → On `tx_ready`=1, exactly one word is accepted.
- Heartbeat: HB_PERIOD=100, `hb_enable`=1, ports idle.
  → words 32'hA55A0000, then 32'hA55A0001, 100 cycles apart, `tx_src`=4'hF.
- Heartbeat priority and overrun: HB_PERIOD=20, port 0 always valid, `tx_ready`=0 for 50 cycles.
  → `hb_missed` pulses at least once.
  → On release, the heartbeat is sent before the next port-0 word, followed by a single heartbeat, not several.
- Reset mid-HOLD: assert `rstn`=0 while `tx_valid`=1.
  → all outputs return to their reset values immediately (asynchronous).
  → After release, port 0 is granted first.
